// File: rtl/threshold_engine.sv
// Pixel thresholding engine: reads each pixel of a RAM range, applies one of four
// threshold functions and writes the result back to the same address.
module threshold_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 20,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] pix_count,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] thr_lo,
    input  logic [DATA_WIDTH-1:0] thr_hi,
    input  logic [DATA_WIDTH-1:0] RAM_out,
    output logic                  RAM_ren,
    output logic                  RAM_wen,
    output logic [ADDR_WIDTH-1:0] RAM_addr,
    output logic [DATA_WIDTH-1:0] RAM_in,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WAIT   = 3'd2,
        S_WRITE  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_remain;
    logic [1:0]            r_mode;
    logic [DATA_WIDTH-1:0] r_thr_lo;
    logic [DATA_WIDTH-1:0] r_thr_hi;
    logic [DATA_WIDTH-1:0] r_pix;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_wait_last;
    logic                  w_last_pix;
    logic                  w_above;
    logic                  w_in_band;

    assign w_wait_last = (r_wait_cnt == CNT_LAST);
    assign w_last_pix  = (r_remain == ADDR_WIDTH'(1));
    assign w_above     = (r_pix > r_thr_lo);
    // An inverted band (hi < lo) can never satisfy both bounds, so it yields all zeros.
    assign w_in_band   = (r_pix >= r_thr_lo) && (r_pix <= r_thr_hi);
    assign RAM_addr    = r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (pix_count != '0) ? S_READ : S_FINISH;
                end
            end
            S_READ:   w_next_state = abort ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (w_wait_last) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = w_last_pix ? S_FINISH : S_READ;
                end
            end
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != S_IDLE);
        done    = (r_state == S_FINISH);
        RAM_ren = (r_state == S_READ);
        RAM_wen = (r_state == S_WRITE) && !abort;
        RAM_in  = (r_state == S_WRITE) ? w_result : '0;
    end

    always_comb begin
        w_result = '0;
        case (r_mode)
            2'b00:   w_result = w_above ? '1 : '0;
            2'b01:   w_result = w_above ? '0 : '1;
            2'b10:   w_result = w_above ? r_pix : '0;
            default: w_result = w_in_band ? '1 : '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_remain   <= '0;
            r_mode     <= '0;
            r_thr_lo   <= '0;
            r_thr_hi   <= '0;
            r_pix      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_wait_cnt <= '0;
                        r_addr     <= base_addr;
                        r_remain   <= pix_count;
                        r_mode     <= mode;
                        r_thr_lo   <= thr_lo;
                        r_thr_hi   <= thr_hi;
                    end
                end
                S_WAIT: begin
                    // Clear on abort too, so the next pass starts its wait from zero.
                    if (abort || w_wait_last) begin
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                    if (w_wait_last) begin
                        r_pix <= RAM_out;
                    end
                end
                S_WRITE: begin
                    if (!abort && !w_last_pix) begin
                        r_addr   <= r_addr + ADDR_WIDTH'(1);
                        r_remain <= r_remain - ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_threshold_engine.sv
// Bench for threshold_engine: two instances (read latency 1 and 3) share stimulus;
// a scoreboard queue per instance holds the expected writes and done latencies.
module tb_threshold_engine;

    localparam int AW = 20;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b1;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] pix_count;
    logic [1:0]    mode;
    logic [DW-1:0] thr_lo;
    logic [DW-1:0] thr_hi;

    logic [1:0]         ren;
    logic [1:0]         wen;
    logic [1:0]         busy;
    logic [1:0]         done;
    logic [1:0][AW-1:0] addr;
    logic [1:0][DW-1:0] din;

    int cyc        = 0;
    int compared   = 0;
    int mismatched = 0;
    int start_s    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp0[$];
    wr_t exp1[$];
    int  dq0[$];
    int  dq1[$];

    logic [DW-1:0] mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    // Each instance gets its own read pipeline modelling a RAM of matching latency.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            localparam int L = (gi == 0) ? 1 : 3;
            logic [DW-1:0] pipe [L];

            always @(posedge clk) begin
                pipe[0] <= ren[gi] ? rd_mem(addr[gi]) : '0;
                for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
            end

            threshold_engine #(
                .DATA_WIDTH(DW),
                .ADDR_WIDTH(AW),
                .RD_LATENCY(L)
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .start    (start),
                .abort    (abort),
                .base_addr(base_addr),
                .pix_count(pix_count),
                .mode     (mode),
                .thr_lo   (thr_lo),
                .thr_hi   (thr_hi),
                .RAM_out  (pipe[L-1]),
                .RAM_ren  (ren[gi]),
                .RAM_wen  (wen[gi]),
                .RAM_addr (addr[gi]),
                .RAM_in   (din[gi]),
                .busy     (busy[gi]),
                .done     (done[gi])
            );
        end
    endgenerate

    task automatic cmp(input string name, input int k, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s inst%0d: got %0h required %0h (cycle %0d)", name, k, act, req, cyc);
        end else begin
            $display("ok   %s inst%0d: %0h (cycle %0d)", name, k, act, cyc);
        end
    endtask

    task automatic check_write(input int k);
        wr_t e;
        logic has;
        has = 1'b0;
        e   = '0;
        if (k == 0 && exp0.size() > 0) begin
            e = exp0.pop_front();
            has = 1'b1;
        end else if (k == 1 && exp1.size() > 0) begin
            e = exp1.pop_front();
            has = 1'b1;
        end
        if (!has) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_write inst%0d: got addr %0h data %0h required no write (cycle %0d)",
                     k, addr[k], din[k], cyc);
        end else begin
            cmp("wr_addr", k, 64'(addr[k]), 64'(e.a));
            cmp("wr_data", k, 64'(din[k]), 64'(e.d));
        end
    endtask

    task automatic check_done(input int k);
        int lat;
        lat = cyc - start_s + 1;
        if ((k == 0 && dq0.size() == 0) || (k == 1 && dq1.size() == 0)) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_done inst%0d: got done at latency %0d required no done", k, lat);
        end else if (k == 0) begin
            cmp("done_latency", k, 64'(lat), 64'(dq0.pop_front()));
        end else begin
            cmp("done_latency", k, 64'(lat), 64'(dq1.pop_front()));
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (ren[k] || wen[k])
                    cmp("strobe_rules", k, 64'({ren[k] & wen[k], done[k] | ~busy[k]}), 64'(0));
                if (wen[k]) check_write(k);
                if (done[k]) check_done(k);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(input int e);
        while (cyc < e) tick();
    endtask

    task automatic push_both(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp0.push_back(w);
        exp1.push_back(w);
    endtask

    task automatic push_one(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        if (k == 0) exp0.push_back(w);
        else        exp1.push_back(w);
    endtask

    task automatic push_done(input int n);
        dq0.push_back(n * 3 + 1);
        dq1.push_back(n * 5 + 1);
    endtask

    task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] n, input logic [1:0] m,
                          input logic [DW-1:0] lo, input logic [DW-1:0] hi);
        base_addr = b;
        pix_count = n;
        mode      = m;
        thr_lo    = lo;
        thr_hi    = hi;
        start     = 1'b1;
        start_s   = cyc + 1;
        tick();
        start     = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((busy != 2'b00) && t < 300) begin
            tick();
            t++;
        end
        cmp("drain_idle", 0, 64'(busy), 64'(0));
        tick();
        tick();
        cmp("queues_empty", 0, 64'(exp0.size() + exp1.size() + dq0.size() + dq1.size()), 64'(0));
    endtask

    task automatic check_reset();
        for (int k = 0; k < 2; k++)
            cmp("reset_state", k, 64'({busy[k], done[k], ren[k], wen[k], addr[k], din[k]}), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 0; abort = 0; base_addr = 0; pix_count = 0; mode = 0; thr_lo = 0; thr_hi = 0;
        #2 rst_n = 1'b0;
        #1 check_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Binary mode, latency 1 gives done at 13
        mem[54] = 8'd0; mem[55] = 8'd127; mem[56] = 8'd128; mem[57] = 8'd255;
        push_both(54, 8'h00); push_both(55, 8'h00); push_both(56, 8'hFF); push_both(57, 8'hFF);
        push_done(4);
        launch(54, 4, 2'b00, 8'd127, 8'd0);
        drain();
        for (int k = 0; k < 2; k++) cmp("addr_hold_idle", k, 64'(addr[k]), 64'(57));

        // Band mode, then inverted band
        mem[100] = 8'd49; mem[101] = 8'd50; mem[102] = 8'd100; mem[103] = 8'd101;
        push_both(100, 8'h00); push_both(101, 8'hFF); push_both(102, 8'hFF); push_both(103, 8'h00);
        push_done(4);
        launch(100, 4, 2'b11, 8'd50, 8'd100);
        drain();
        push_both(100, 8'h00); push_both(101, 8'h00); push_both(102, 8'h00); push_both(103, 8'h00);
        push_done(4);
        launch(100, 4, 2'b11, 8'd100, 8'd50);
        drain();

        // Inverse binary and to-zero
        mem[200] = 8'd200; mem[201] = 8'd10;
        push_both(200, 8'h00); push_both(201, 8'hFF);
        push_done(2);
        launch(200, 2, 2'b01, 8'd127, 8'd0);
        drain();
        push_both(200, 8'd200); push_both(201, 8'h00);
        push_done(2);
        launch(200, 2, 2'b10, 8'd127, 8'd0);
        drain();

        // Zero-length pass
        push_done(0);
        launch(500, 0, 2'b00, 8'd0, 8'd0);
        drain();

        // Address wrap, with a start and input changes mid-pass
        mem[20'hFFFFE] = 8'd10; mem[20'hFFFFF] = 8'd200; mem[20'h00000] = 8'd130; mem[20'h00001] = 8'd127;
        push_both(20'hFFFFE, 8'h00); push_both(20'hFFFFF, 8'hFF);
        push_both(20'h00000, 8'hFF); push_both(20'h00001, 8'h00);
        push_done(4);
        launch(20'hFFFFE, 4, 2'b00, 8'd127, 8'd0);
        at_cycle(start_s + 3);
        start = 1'b1; base_addr = 5; pix_count = 1; mode = 2'b01; thr_lo = 8'd0;
        tick();
        start = 1'b0;
        drain();

        // Abort at cycle 7: inst0 in WAIT of pixel 3, inst1 in WAIT of pixel 2
        mem[300] = 8'd1; mem[301] = 8'd2; mem[302] = 8'd3; mem[303] = 8'd4;
        push_one(0, 300, 8'd1); push_one(0, 301, 8'd2); push_one(1, 300, 8'd1);
        launch(300, 4, 2'b10, 8'd0, 8'd0);
        at_cycle(start_s + 7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int k = 0; k < 2; k++) cmp("idle_after_abort", k, 64'(busy[k]), 64'(0));
        drain();

        // Abort at cycle 12: inst0 in FINISH (ignored), inst1 in WAIT of pixel 3
        push_one(0, 300, 8'd1); push_one(0, 301, 8'd2); push_one(0, 302, 8'd3); push_one(0, 303, 8'd4);
        push_one(1, 300, 8'd1); push_one(1, 301, 8'd2);
        dq0.push_back(13);
        launch(300, 4, 2'b10, 8'd0, 8'd0);
        at_cycle(start_s + 12);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int k = 0; k < 2; k++) cmp("idle_after_abort", k, 64'(busy[k]), 64'(0));
        drain();

        // Abort at cycle 5: inst0 in WRITE of pixel 2 (write suppressed), inst1 in READ
        push_both(300, 8'd1);
        launch(300, 4, 2'b10, 8'd0, 8'd0);
        at_cycle(start_s + 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        drain();

        // Start and abort together in IDLE: start wins
        mem[400] = 8'd200;
        push_both(400, 8'hFF);
        push_done(1);
        abort = 1'b1;
        launch(400, 1, 2'b00, 8'd127, 8'd0);
        abort = 1'b0;
        drain();

        // Reset mid-pass, then a fresh pass
        push_one(0, 54, 8'h00);
        launch(54, 4, 2'b00, 8'd127, 8'd0);
        at_cycle(start_s + 3);
        rst_n = 1'b0;
        #1 check_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        push_both(100, 8'h00); push_both(101, 8'hFF);
        push_done(2);
        launch(100, 2, 2'b11, 8'd50, 8'd100);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/threshold_engine.md
THRESHOLD_ENGINE -- requirements
Module: threshold_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 Parameter ADDR_WIDTH, default 20, RAM address width in bits.
REQ-003 Parameter RD_LATENCY, default 1, range 1-4, cycles from the RAM_ren sample edge until RAM_out is valid.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle request to begin a pass; sampled in IDLE only.
REQ-008 abort  in  1  terminates a pass in progress.
REQ-009 base_addr  in  ADDR_WIDTH  first pixel address, latched at start.
REQ-010 pix_count  in  ADDR_WIDTH  number of pixels to process, latched at start.
REQ-011 mode  in  2  operation, latched at start: 00 binary, 01 inverse binary, 10 to-zero, 11 band.
REQ-012 thr_lo, thr_hi  in  DATA_WIDTH each  thresholds, latched at start.
REQ-013 RAM_out  in  DATA_WIDTH  read data from RAM.
REQ-014 RAM_ren, RAM_wen  out  1 each  RAM read strobe and write strobe.
REQ-015 RAM_addr  out  ADDR_WIDTH  RAM address.
REQ-016 RAM_in  out  DATA_WIDTH  RAM write data.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse when a pass completes normally.

Function
REQ-019 States SHALL be IDLE, READ, WAIT, WRITE and FINISH.
REQ-020 IDLE->READ on start when pix_count!=0; IDLE->FINISH on start when pix_count==0; otherwise stay in IDLE.
REQ-021 READ SHALL assert RAM_ren=1 with RAM_addr holding the current pixel address, then go to WAIT.
REQ-022 WAIT SHALL last exactly RD_LATENCY cycles, counted by an internal counter, and capture RAM_out into the pixel buffer on its last cycle.
REQ-023 WRITE SHALL assert RAM_wen=1 with RAM_in=f(buffer) at the same address.
REQ-024 Leaving WRITE: go to FINISH if this was the last pixel; otherwise increment RAM_addr by 1 modulo 2^ADDR_WIDTH and return to READ.
REQ-025 FINISH SHALL assert done=1 for one cycle, then go to IDLE.
REQ-026 Each pixel SHALL cost 2+RD_LATENCY cycles; a pass SHALL take N*(2+RD_LATENCY)+1 cycles from the start edge to done.
REQ-027 RAM_ren and RAM_wen SHALL never be high in the same cycle, and both SHALL be 0 in IDLE and FINISH.
REQ-028 f(p) with MAX = all ones, all comparisons unsigned:
  - mode 00: p>thr_lo ? MAX : 0.
  - mode 01: p>thr_lo ? 0 : MAX.
  - mode 10: p>thr_lo ? p : 0.
  - mode 11: thr_lo<=p<=thr_hi ? MAX : 0.
REQ-029 In band mode with thr_hi<thr_lo, every output SHALL be 0.
REQ-030 start while busy=1 SHALL be ignored, and the latched configuration SHALL stay unchanged.
REQ-031 Input changes after start SHALL not affect the pass in progress.
REQ-032 abort=1 in READ, WAIT or WRITE SHALL force IDLE on the next edge.
  - No RAM_wen in the abort cycle, even if the state is WRITE.
  - No done pulse.
REQ-033 abort in FINISH SHALL be ignored; done still pulses.
REQ-034 If abort and start are both high in IDLE, start SHALL win.
REQ-035 Address wrap: a pass whose range crosses 2^ADDR_WIDTH-1 SHALL continue at address 0.
REQ-036 RAM_addr SHALL hold its value in IDLE after a pass.

Reset
REQ-037 On rst_n=0, asynchronously:
  - state=IDLE, busy=0, done=0, RAM_ren=0, RAM_wen=0.
  - RAM_addr=0, RAM_in=0, WAIT counter=0, latched configuration=0.
REQ-038 Reset asserted mid-pass SHALL abandon the pass with no further RAM access; the first start after reset release SHALL begin a fresh pass.

Verification
REQ-039 Mode 00, thr_lo=127, base=54, count=4, RAM data 0,127,128,255, RD_LATENCY=1 -> writes 0,0,255,255 at addresses 54-57; done pulse 13 cycles after the start edge.
REQ-040 Mode 11, thr_lo=50, thr_hi=100, data 49,50,100,101 -> writes 0,255,255,0; repeat with thr_lo=100, thr_hi=50 -> all writes 0.
REQ-041 Modes 01 and 10, thr_lo=127, data 200,10 -> mode 01 writes 0,255; mode 10 writes 200,0.
REQ-042 count=0 -> no RAM strobes; done pulses on the cycle after the start edge.
REQ-043 base=2^ADDR_WIDTH-2, count=4 -> write addresses FFFFE, FFFFF, 0, 1 (ADDR_WIDTH=20); start re-pulsed mid-pass is ignored.
REQ-044 abort during the WAIT of pixel 3 -> IDLE on the next edge with no write of pixel 3 and no done; with RD_LATENCY=3 each pixel takes 5 cycles.
